// File: rtl/mux_nway_pipe.sv
// Registered N-way word multiplexer with per-channel valid/ready handshake.
// Selects a channel by explicit index or round-robin scan into a one-entry output register.
module mux_nway_pipe #(
    parameter  int WIDTH  = 16,
    parameter  int NUM_CH = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0] ch_data [NUM_CH];

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;

    logic [SEL_W-1:0] rr_grant;
    logic             rr_found;
    logic [SEL_W-1:0] cand;
    logic             cand_ok;
    logic             can_load;
    logic             accept;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // First valid channel at or after ptr, wrapping past NUM_CH-1.
    always_comb begin
        logic [SEL_W:0] sum;
        rr_found = 1'b0;
        rr_grant = '0;
        sum      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum = {1'b0, ptr_q} + (SEL_W+1)'(k);
            if (sum >= (SEL_W+1)'(NUM_CH)) begin
                sum = sum - (SEL_W+1)'(NUM_CH);
            end
            if (!rr_found && in_valid[sum[SEL_W-1:0]]) begin
                rr_found = 1'b1;
                rr_grant = sum[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        can_load = !out_valid_q || out_ready;
        cand     = mode ? rr_grant : sel;
        cand_ok  = mode ? rr_found : (int'(sel) < NUM_CH);
        in_ready = '0;
        accept   = 1'b0;
        if (cand_ok && can_load) begin
            in_ready[cand] = 1'b1;
            accept         = in_valid[cand];
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_data_d  = ch_data[cand];
            out_ch_d    = cand;
            out_valid_d = 1'b1;
            if (mode) begin
                ptr_d = (int'(rr_grant) == NUM_CH - 1) ? '0 : rr_grant + SEL_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/mux_nway_pipe.md
# mux_nway_pipe

Parametrised, registered N-way word multiplexer with per-channel valid/ready handshaking. It selects one of NUM_CH input channels of WIDTH bits each, either by an explicit select or by round-robin scan, and holds the result in a one-entry output register until the consumer takes it. It is the pipelined, handshaked successor to the fixed 16-bit 8-way combinational multiplexer, for use between the register/memory datapath and downstream consumers.

## Interface
- WIDTH, 16, data width per channel in bits (≥1)
- NUM_CH, 8, number of input channels (≥2)
- SEL_W, $clog2(NUM_CH), select/channel-index width (derived localparam, not overridable)

- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  reset; synchronous, active-low
- in_data  input  NUM_CH*WIDTH  flat channel bus; channel i at [i*WIDTH +: WIDTH]
- in_valid  input  NUM_CH  per-channel valid
- in_ready  output  NUM_CH  per-channel ready (combinational); at most one bit high per cycle
- mode  input  1  0 = fixed select via sel, 1 = round-robin scan
- sel  input  SEL_W  channel index used when mode=0
- out_data  output  WIDTH  registered selected word
- out_ch  output  SEL_W  registered index of the channel that supplied out_data
- out_valid  output  1  out_data/out_ch hold an untaken word
- out_ready  input  1  consumer accepts the word when high with out_valid

## Operation
- Reset (rst_n=0 at a rising edge): out_valid=0, out_data=0, out_ch=0, scan pointer ptr=0. Reset overrides any transfer in the same cycle; a held word is discarded.
- can_load = !out_valid | out_ready.
- Fixed mode (mode=0):
  - Candidate is sel. in_ready[sel] = can_load; all other in_ready bits are 0.
  - If sel ≥ NUM_CH (non-power-of-2 NUM_CH), all in_ready bits are 0 and nothing is accepted.
  - ptr is unchanged in this mode.
- Round-robin mode (mode=1):
  - Grant goes to the first channel with in_valid=1, searching ptr, ptr+1, … NUM_CH-1, 0, … ptr-1.
  - in_ready[grant] = can_load; all other in_ready bits are 0.
  - If no in_valid bit is set, there is no grant, all in_ready bits are 0, and ptr holds.
  - On acceptance, ptr ← grant+1, wrapping from NUM_CH-1 to 0.
- Acceptance means in_valid[c] & in_ready[c] for channel c. On the next edge:
  - out_data ← channel c data
  - out_ch ← c
  - out_valid ← 1
- Drain without refill: out_valid & out_ready with no acceptance → out_valid ← 0. out_data and out_ch keep their last values.
- Stall: out_valid & !out_ready → out_data and out_ch are held stable and no channel is granted ready.
- Simultaneous drain and accept in one cycle → the register is overwritten with the new word and out_valid stays 1. This gives one word per cycle.
- mode and sel are sampled combinationally every cycle. A change takes effect immediately and never corrupts a held word. ptr persists across mode changes.

## Timing
- Latency: 1 cycle from input acceptance edge to out_valid/out_data.
- Throughput: 1 word per cycle while out_ready=1 and a candidate channel is valid.
- in_ready depends combinationally on in_valid, mode, sel, out_valid and out_ready. No output depends combinationally on in_data.
- Inputs do not need to hold data after acceptance. A channel with in_valid=1 must hold in_data stable until it is accepted.
- Round-robin fairness: with all channels continuously valid, the grant sequence is 0,1,…,NUM_CH-1,0,… after reset.

## Test plan
All scenarios use WIDTH=16, NUM_CH=8. Channel data 0..7 = 0x0000, 0x5555, 0xAAAA, 0xFFFF, 0xCCCC, 0xF0F0, 0xFF00, 0xE38E. All in_valid=1 unless stated.

1. Fixed sweep: mode=0, out_ready=1, sel stepped 0..7 one per cycle → each next cycle out_valid=1, out_ch=sel, out_data = the matching channel word (e.g. sel=6 → 0xFF00).
2. Backpressure: mode=0, sel=3, out_ready=0 for 4 cycles → out_data=0xFFFF held, out_valid=1, in_ready=0; sel changed to 5 while stalled → still 0xFFFF; out_ready=1 → next cycle 0xF0F0, out_ch=5.
3. Round-robin fairness: mode=1, out_ready=1 for 10 cycles → out_ch sequence 0,1,2,3,4,5,6,7,0,1 with matching data.
4. Sparse round-robin: in_valid=8'b1000_0100, ptr=0 → grants 2,7,2,7…; then in_valid=0 → out_valid drops to 0 after the drain and ptr holds.
5. Reset mid-operation: rst_n=0 for one edge while out_valid=1 and out_ready=0 → out_valid=0, out_data=0, out_ch=0; after release in round-robin mode, the first grant is channel 0.
6. Single-cycle drain+refill and mode switch: mode=1 for 3 transfers (ch 0,1,2), then mode=0 with sel=7, then back to mode=1 → outputs ch 0,1,2,7,3 (ptr retained at 3), and out_valid never drops.
